// File: rtl/elastic_config_loader_pkg.sv
// Shared widths, state type and helpers for the elastic config loader.
// Field widths mirror the PE array's config bus.
package elastic_config_loader_pkg;

  localparam int CONTEXT_SIZE = 4;
  localparam int CONTEXT_SIZE_BIT_LENGTH = 2;
  localparam int DATA_WIDTH = 16;
  localparam int INPUT_NUM_BIT_LENGTH = 3;
  localparam int NEIGHBOR_PE_NUM = 4;
  localparam int OPERATION_BIT_LENGTH = 5;
  localparam int CONFIG_LOADER_PE_NUM = 16;
  localparam int CONFIG_LOADER_PE_NUM_BIT_LENGTH =
    $clog2(CONFIG_LOADER_PE_NUM);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    RUN
  } ElasticConfigLoaderState;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elastic_config_index_counter.sv
// PE/context write pointer: context-major order, skips masked-off PEs,
// flags the final record of a load.
module elastic_config_index_counter
  import elastic_config_loader_pkg::*;
#(
  parameter int PE_NUM = 16,
  parameter int PW = 4,
  parameter int CW = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              step,
  input  logic [PE_NUM-1:0] mask_in,
  input  logic [CW-1:0]     max_id,
  output logic [PW-1:0]     pe,
  output logic [CW-1:0]     ctx,
  output logic              last,
  output logic              empty
);

  logic [PE_NUM-1:0] mask_q;
  logic [PW-1:0]     pe_q;
  logic [CW-1:0]     ctx_q;
  logic [PW-1:0]     nxt;
  logic              has_nxt;

  function automatic logic [PW-1:0] first_set(
    input logic [PE_NUM-1:0] m
  );
    logic [PW-1:0] r;
    r = '0;
    for (int i = PE_NUM - 1; i >= 0; i--)
      if (m[i]) r = PW'(i);
    return r;
  endfunction

  // Lowest enabled PE above the current one; none means row wrap.
  always_comb begin
    nxt = '0;
    has_nxt = 1'b0;
    for (int i = PE_NUM - 1; i >= 0; i--) begin
      if (mask_q[i] && (PW'(i) > pe_q)) begin
        nxt = PW'(i);
        has_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_q <= '0;
      pe_q <= '0;
      ctx_q <= '0;
    end else if (clear) begin
      mask_q <= mask_in;
      pe_q <= first_set(mask_in);
      ctx_q <= '0;
    end else if (step) begin
      if (has_nxt) begin
        pe_q <= nxt;
      end else begin
        pe_q <= first_set(mask_q);
        ctx_q <= ctx_q + 1'b1;
      end
    end
  end

  assign pe = pe_q;
  assign ctx = ctx_q;
  assign last = !has_nxt && (ctx_q == max_id);
  assign empty = (mask_q == '0);

endmodule

// File: rtl/elastic_config_loader.sv
// Streams config records into the PE array, then launches execution.
// Define ELASTIC_CONFIG_LOADER_PE_MASK_EN to add per-PE load skipping.
module elastic_config_loader
  import elastic_config_loader_pkg::*;
#(
  parameter int PE_NUM = 16,
  parameter int CONTEXT_SIZE =
    elastic_config_loader_pkg::CONTEXT_SIZE,
  parameter int DATA_WIDTH =
    elastic_config_loader_pkg::DATA_WIDTH,
  parameter int INPUT_NUM_BIT_LENGTH =
    elastic_config_loader_pkg::INPUT_NUM_BIT_LENGTH,
  parameter int NEIGHBOR_PE_NUM =
    elastic_config_loader_pkg::NEIGHBOR_PE_NUM,
  parameter int OPERATION_BIT_LENGTH =
    elastic_config_loader_pkg::OPERATION_BIT_LENGTH,
  localparam int CW = idx_bits(CONTEXT_SIZE),
  localparam int IW = INPUT_NUM_BIT_LENGTH,
  localparam int NW = NEIGHBOR_PE_NUM,
  localparam int OW = OPERATION_BIT_LENGTH,
  localparam int DW = DATA_WIDTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_req,
  input  logic [CW-1:0]     context_max_id,
`ifdef ELASTIC_CONFIG_LOADER_PE_MASK_EN
  input  logic [PE_NUM-1:0] pe_enable_mask,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [IW-1:0]     cfg_input_PE_index_1,
  input  logic [IW-1:0]     cfg_input_PE_index_2,
  input  logic [NW-1:0]     cfg_output_PE_index,
  input  logic [OW-1:0]     cfg_op,
  input  logic [DW-1:0]     cfg_const_data,
  input  logic              halt,
  output logic [IW-1:0]     config_input_PE_index_1,
  output logic [IW-1:0]     config_input_PE_index_2,
  output logic [NW-1:0]     config_output_PE_index,
  output logic [OW-1:0]     config_op,
  output logic [DW-1:0]     config_const_data,
  output logic [CW-1:0]     config_index,
  output logic [PE_NUM-1:0] write_config_data,
  output logic [CW-1:0]     mapping_context_max_id,
  output logic              start_exec,
  output logic              busy,
  output logic              exec_active
);

  localparam int PW = idx_bits(PE_NUM);
  localparam logic [PE_NUM-1:0] ONE = 1;

  ElasticConfigLoaderState state_q, state_d;

  logic [CW-1:0]     max_q;
  logic [PE_NUM-1:0] mask;
  logic [PW-1:0]     pe;
  logic [CW-1:0]     ctx;
  logic              last;
  logic              empty;
  logic              start_load;
  logic              accept;

`ifdef ELASTIC_CONFIG_LOADER_PE_MASK_EN
  assign mask = pe_enable_mask;
`else
  assign mask = '1;
`endif

  assign start_load = (state_q == IDLE) && load_req;
  assign accept = cfg_valid && cfg_ready;

  elastic_config_index_counter #(
    .PE_NUM(PE_NUM),
    .PW(PW),
    .CW(CW)
  ) u_cnt (
    .clk(clk),
    .reset_n(reset_n),
    .clear(start_load),
    .step(accept),
    .mask_in(mask),
    .max_id(max_q),
    .pe(pe),
    .ctx(ctx),
    .last(last),
    .empty(empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (load_req) state_d = LOAD;
      LOAD: if (empty || (accept && last)) state_d = START;
      START: state_d = RUN;
      RUN: if (halt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      max_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_load) max_q <= context_max_id;
    end
  end

  // Broadcast fields are registered; the strobe marks the target PE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      write_config_data <= '0;
      config_input_PE_index_1 <= '0;
      config_input_PE_index_2 <= '0;
      config_output_PE_index <= '0;
      config_op <= '0;
      config_const_data <= '0;
      config_index <= '0;
    end else begin
      write_config_data <= accept ? (ONE << pe) : '0;
      if (accept) begin
        config_input_PE_index_1 <= cfg_input_PE_index_1;
        config_input_PE_index_2 <= cfg_input_PE_index_2;
        config_output_PE_index <= cfg_output_PE_index;
        config_op <= cfg_op;
        config_const_data <= cfg_const_data;
        config_index <= ctx;
      end
    end
  end

  assign cfg_ready = (state_q == LOAD) && !empty;
  assign mapping_context_max_id = max_q;
  assign start_exec = (state_q == START);
  assign busy = (state_q == LOAD) || (state_q == START);
  assign exec_active = (state_q == RUN);

endmodule

// File: tb/tb_elastic_config_loader.sv
// Directed bench for elastic_config_loader with a write scoreboard.
// Optional mask tests follow ELASTIC_CONFIG_LOADER_PE_MASK_EN.
module tb_elastic_config_loader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load_req = 1'b0;
  logic [1:0] context_max_id = '0;
  logic [3:0] pe_mask = 4'hF;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [2:0] cfg_in1 = '0;
  logic [2:0] cfg_in2 = '0;
  logic [3:0] cfg_out = '0;
  logic [4:0] cfg_op = '0;
  logic [15:0] cfg_data = '0;
  logic       halt = 1'b0;
  logic [2:0] config_input_PE_index_1;
  logic [2:0] config_input_PE_index_2;
  logic [3:0] config_output_PE_index;
  logic [4:0] config_op;
  logic [15:0] config_const_data;
  logic [1:0] config_index;
  logic [3:0] write_config_data;
  logic [1:0] mapping_context_max_id;
  logic       start_exec;
  logic       busy;
  logic       exec_active;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0]  wr;
    logic [1:0]  idx;
    logic [4:0]  op;
    logic [15:0] data;
    logic [2:0]  in1;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  elastic_config_loader #(
    .PE_NUM(4),
    .CONTEXT_SIZE(4),
    .DATA_WIDTH(16),
    .INPUT_NUM_BIT_LENGTH(3),
    .NEIGHBOR_PE_NUM(4),
    .OPERATION_BIT_LENGTH(5)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .load_req(load_req),
    .context_max_id(context_max_id),
`ifdef ELASTIC_CONFIG_LOADER_PE_MASK_EN
    .pe_enable_mask(pe_mask),
`endif
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_input_PE_index_1(cfg_in1),
    .cfg_input_PE_index_2(cfg_in2),
    .cfg_output_PE_index(cfg_out),
    .cfg_op(cfg_op),
    .cfg_const_data(cfg_data),
    .halt(halt),
    .config_input_PE_index_1(config_input_PE_index_1),
    .config_input_PE_index_2(config_input_PE_index_2),
    .config_output_PE_index(config_output_PE_index),
    .config_op(config_op),
    .config_const_data(config_const_data),
    .config_index(config_index),
    .write_config_data(write_config_data),
    .mapping_context_max_id(mapping_context_max_id),
    .start_exec(start_exec),
    .busy(busy),
    .exec_active(exec_active)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive record fields and queue the write it must produce.
  task automatic drive_rec(input int rec, input int pe, input int ctx);
    exp_t e;
    cfg_op = 5'(rec);
    cfg_data = 16'hA000 + 16'(rec);
    cfg_in1 = 3'(rec);
    e.wr = 4'(1 << pe);
    e.idx = 2'(ctx);
    e.op = 5'(rec);
    e.data = 16'hA000 + 16'(rec);
    e.in1 = 3'(rec);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (write_config_data !== '0) begin
      if (sb.size() == 0) begin
        chk("spurious_write", 32'(write_config_data), 0);
      end else begin
        e = sb.pop_front();
        chk("wr_strobe", 32'(write_config_data), 32'(e.wr));
        chk("wr_index", 32'(config_index), 32'(e.idx));
        chk("wr_op", 32'(config_op), 32'(e.op));
        chk("wr_data", 32'(config_const_data), 32'(e.data));
        chk("wr_in1", 32'(config_input_PE_index_1), 32'(e.in1));
      end
    end
  end

  task automatic do_load(input int mx, input bit tog,
                         input logic [3:0] mask);
    int en[$];
    int n;
    int rec;
    int c;
    for (int i = 0; i < 4; i++)
      if (mask[i]) en.push_back(i);
    n = en.size() * (mx + 1);
    rec = 0;
    c = 0;
    load_req = 1'b1;
    context_max_id = 2'(mx);
    pe_mask = mask;
    cyc();
    load_req = 1'b0;
    chk("load_busy", 32'(busy), 1);
    chk("load_map", 32'(mapping_context_max_id), 32'(mx));
    while (rec < n && c < 200) begin
      chk("load_ready", 32'(cfg_ready), 1);
      chk("load_no_start", 32'(start_exec), 0);
      cfg_valid = tog ? ((c % 2) == 0) : 1'b1;
      if (cfg_valid) begin
        drive_rec(rec, en[rec % en.size()], rec / en.size());
        rec++;
      end
      c++;
      cyc();
    end
    cfg_valid = 1'b0;
    if (rec < n) chk("load_timeout", 32'(rec), 32'(n));
    chk("start_pulse", 32'(start_exec), 1);
    chk("start_busy", 32'(busy), 1);
    chk("start_ready", 32'(cfg_ready), 0);
    cyc();
    chk("run_active", 32'(exec_active), 1);
    chk("run_start_low", 32'(start_exec), 0);
    chk("run_busy_low", 32'(busy), 0);
    chk("sb_drained", 32'(sb.size()), 0);
  endtask

  task automatic do_halt();
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    chk("halt_active", 32'(exec_active), 0);
    chk("halt_busy", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    cyc();
    cyc();
    reset_n = 1'b1;
    chk("rst_ready", 32'(cfg_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_active", 32'(exec_active), 0);
    chk("rst_start", 32'(start_exec), 0);
    chk("rst_write", 32'(write_config_data), 0);
    chk("rst_index", 32'(config_index), 0);
    chk("rst_map", 32'(mapping_context_max_id), 0);
    chk("rst_op", 32'(config_op), 0);

    do_load(1, 1'b0, 4'hF);

    load_req = 1'b1;
    cyc();
    load_req = 1'b0;
    chk("run_ign_load", 32'(exec_active), 1);
    chk("run_ign_busy", 32'(busy), 0);
    chk("run_ign_ready", 32'(cfg_ready), 0);
    do_halt();

    do_load(1, 1'b1, 4'hF);
    do_halt();

    load_req = 1'b1;
    context_max_id = 2'd1;
    cyc();
    load_req = 1'b0;
    cfg_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      drive_rec(r, r, 0);
      cyc();
    end
    cfg_valid = 1'b0;
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    chk("mid_rst_write", 32'(write_config_data), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(cfg_ready), 0);
    chk("mid_rst_start", 32'(start_exec), 0);
    chk("mid_rst_active", 32'(exec_active), 0);
    chk("mid_rst_map", 32'(mapping_context_max_id), 0);
    chk("mid_rst_op", 32'(config_op), 0);
    chk("mid_rst_sb", 32'(sb.size()), 0);

    do_load(0, 1'b0, 4'hF);
    do_halt();

    do_load(3, 1'b0, 4'hF);
    chk("max_map", 32'(mapping_context_max_id), 3);
    do_halt();

`ifdef ELASTIC_CONFIG_LOADER_PE_MASK_EN
    do_load(0, 1'b0, 4'b1010);
    do_halt();
    do_load(1, 1'b1, 4'b0110);
    do_halt();

    load_req = 1'b1;
    pe_mask = 4'b0000;
    context_max_id = 2'd2;
    cyc();
    load_req = 1'b0;
    chk("m0_busy", 32'(busy), 1);
    chk("m0_ready", 32'(cfg_ready), 0);
    chk("m0_no_start", 32'(start_exec), 0);
    cyc();
    chk("m0_start", 32'(start_exec), 1);
    chk("m0_write", 32'(write_config_data), 0);
    cyc();
    chk("m0_active", 32'(exec_active), 1);
    do_halt();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/elastic_config_loader.md
# elastic_config_loader

Sequencer that loads per-context configuration into an array of `ElasticPE` instances and then launches execution. It consumes a valid/ready stream of configuration records and drives the shared PE config bus (`config_*`, `config_index`) with a one-hot per-PE `write_config_data`. It then sets `mapping_context_max_id`, pulses `start_exec`, and holds the array in a run state until halted. It sits between the host/DMA config source and the CGRA top level.

## Interface
- `PE_NUM`, 16, number of PEs on the config bus (≥1)
- `CONTEXT_SIZE`, `CONTEXT_SIZE` from param.v, context slots per PE (power of two)
- `DATA_WIDTH`, `INPUT_NUM_BIT_LENGTH`, `NEIGHBOR_PE_NUM`, `OPERATION_BIT_LENGTH`, from param.v, config field widths
- `clk` in 1 clock
- `reset_n` in 1 — synchronous, active-low reset
- `load_req` in 1 — start a load sequence; sampled only in IDLE
- `context_max_id` in CONTEXT_SIZE_BIT_LENGTH — last context id; latched on accepted `load_req`
- `cfg_valid` in 1, `cfg_ready` out 1 — record handshake
- `cfg_input_PE_index_1` / `_2` in INPUT_NUM_BIT_LENGTH each, `cfg_output_PE_index` in NEIGHBOR_PE_NUM, `cfg_op` in OPERATION_BIT_LENGTH, `cfg_const_data` in DATA_WIDTH — record fields
- `halt` in 1 — leave RUN
- `config_input_PE_index_1` / `_2`, `config_output_PE_index`, `config_op`, `config_const_data` out (widths as cfg_*) — registered broadcast fields
- `config_index` out CONTEXT_SIZE_BIT_LENGTH — target context
- `write_config_data` out PE_NUM — one-hot write strobe
- `mapping_context_max_id` out CONTEXT_SIZE_BIT_LENGTH
- `start_exec` out 1 — one-cycle pulse
- `busy` out 1 — high in LOAD/START
- `exec_active` out 1 — high in RUN

## Operation
- FSM states: IDLE, LOAD, START, RUN.
  - IDLE→LOAD on `load_req`. Latch `context_max_id`; clear pe counter and ctx counter.
  - LOAD: `cfg_ready`=1. Each accept (`cfg_valid && cfg_ready`) writes one record to PE `pe`, context `ctx`.
  - Ordering is context-major: `pe` increments 0..PE_NUM-1, then wraps to 0 and `ctx` increments.
  - The accept with `pe==PE_NUM-1 && ctx==max` is the last one: LOAD→START.
  - START: one cycle. `start_exec`=1, then →RUN.
  - RUN: `exec_active`=1. `halt` → IDLE next cycle. `load_req` in RUN is ignored.
- Total records consumed per load = PE_NUM × (max+1).
- `mapping_context_max_id` is updated from the latched value on entry to LOAD and holds until the next load.
- `load_req` outside IDLE is ignored. `halt` outside RUN is ignored.
- `cfg_valid` stalls in LOAD freeze the counters. There is no timeout.
- Reset (any state, including mid-load) → IDLE; the partially written PE config is stale and a reload is required.
- Reset values: all outputs 0; `cfg_ready`=0.

## Timing
- Record accepted in cycle t → `write_config_data[pe]`=1 and all `config_*`/`config_index` valid in cycle t+1, for exactly one cycle. In t+1, `write_config_data` is 0 if there was no accept in t.
- Back-to-back accepts give one write per cycle; throughput is 1 record/cycle.
- Last accept at t → final write at t+1, `start_exec` at t+1 (START). The PE captures the config on the t+1 edge and `start_exec` on the same edge; the final write lands before context 0 is used. `exec_active` from t+2.
- `load_req` at t in IDLE → `busy` and `cfg_ready` from t+1.
- `halt` at t in RUN → `exec_active`=0 at t+1.

## Configuration
- `ELASTIC_CONFIG_LOADER_PE_MASK_EN` defined:
  - Adds input `pe_enable_mask` [PE_NUM], latched with `load_req`.
  - PEs with mask bit 0 are skipped: no record is consumed and no strobe is issued. The counter advances to the next enabled PE in the same cycle (combinational priority search).
  - Records per load = popcount(mask) × (max+1).
  - All-zero mask: IDLE→LOAD→START with no records; `cfg_ready` stays 0.
- Undefined: no port; all PEs are loaded.

## Structure
- Shared package `param.v`:
  - Existing `CONTEXT_SIZE`, `CONTEXT_SIZE_BIT_LENGTH`, field widths.
  - New typedef `ElasticConfigLoaderState` (IDLE/LOAD/START/RUN).
  - New `CONFIG_LOADER_PE_NUM_BIT_LENGTH` = clog2(PE_NUM).
- One sub-module, `elastic_config_index_counter`:
  - pe/ctx counter with step, wrap, last-record detect and optional mask skip.
  - The FSM and output registers stay in the top.

## Test plan
- PE_NUM=4, max=1, `cfg_valid` held high, `cfg_op`=record number 0..7 → 8 strobes on consecutive cycles. Order: PE0..3 ctx0, then PE0..3 ctx1, with `config_op` 0..7. `start_exec` is one cycle, coincident with the 8th write; `exec_active`=1 next cycle.
- Same load with `cfg_valid` toggling every cycle → strobes every other cycle, same order; `start_exec` only after the 8th accept.
- Reset asserted after the 3rd accept → next cycle all outputs 0, state IDLE. A new `load_req` restarts at PE0/ctx0.
- In RUN: `load_req`=1 → no change. `halt`=1 → `exec_active`=0 next cycle; a following `load_req` accepted.
- max=CONTEXT_SIZE-1, PE_NUM=4 → 4×CONTEXT_SIZE writes; `config_index` reaches CONTEXT_SIZE-1 with no wrap before START.
- With `ELASTIC_CONFIG_LOADER_PE_MASK_EN`, mask=4'b1010, max=0 → exactly 2 records consumed; strobes `write_config_data`=4'b0010 then 4'b1000; then `start_exec`. Mask=0 → `start_exec` 2 cycles after `load_req`.
